imem_arb: RTL and testbench
===========================

# imem_arb

Two-requester arbiter for the single-port instruction memory. It shares the memory between the fetch stage (port F) and a load/store/loader port (port L), routes one-cycle-latency read data back to its owner, and kills a fetch response made stale by a redirect. It sits between the fetch stage's PC/mem_cs outputs and the memory macro.

## Interface
- XLEN, 32, address/data width.
- MAX_L_RUN, 4, maximum consecutive L grants while F is waiting (1..15).
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- f_req  in  1  fetch request (driven by fetch mem_cs).
- f_addr  in  XLEN  fetch address (fetch PC).
- f_flush  in  1  redirect (Jump/start); kills the F response in flight.
- f_gnt  out  1  F request accepted this cycle; fetch must hold PC when f_req=1 and f_gnt=0.
- f_rvalid  out  1  F read data valid.
- f_rdata  out  XLEN  F read data.
- l_req  in  1  L request.
- l_we  in  1  L write.
- l_be  in  4  L byte enables (writes only).
- l_addr  in  XLEN  L address.
- l_wdata  in  XLEN  L write data.
- l_lock  in  1  keep L ownership next cycle (read-modify-write).
- l_gnt  out  1  L request accepted.
- l_rvalid  out  1  L read data valid (reads only).
- l_rdata  out  XLEN  L read data.
- mem_en, mem_we  out  1  memory enable/write.
- mem_be  out  4  byte enables; 4'hF for all reads.
- mem_addr  out  XLEN  memory address.
- mem_wdata  out  XLEN  memory write data.
- mem_rdata  in  XLEN  read data, valid one cycle after mem_en&~mem_we.

## Operation
- Grant is combinational from the request and the registered state. At most one grant per cycle. The memory signals are muxed from the granted port, and mem_en equals f_gnt|l_gnt.
- Priority:
  - l_req wins by default.
  - F wins if f_req=1 and run_cnt==MAX_L_RUN.
  - When locked (lock_q=1), only L can be granted. f_gnt=0 even if l_req=0.
- run_cnt, 4 bits:
  - Increments on an L grant while f_req=1, saturating at MAX_L_RUN.
  - Clears on any F grant, or when f_req=0.
- lock_q is set to l_gnt&l_lock. It clears on any cycle without l_gnt&l_lock. A lock longer than one cycle is allowed. run_cnt does not override a lock.
- owner_q (2-bit enum NONE/F/L) records the owner of a granted read. It is NONE for writes and idle cycles.
- Next cycle routing:
  - f_rvalid=(owner_q==F)&~kill.
  - l_rvalid=(owner_q==L).
  - Both rdata outputs are driven by mem_rdata.
- The kill condition is f_flush asserted in the response cycle, or f_flush asserted in the grant cycle (registered as kill_q). A killed response never asserts f_rvalid. A new F request in the same cycle as f_flush may still be granted; its response is not killed by that same flush.
- Writes produce no rvalid.

## Timing
- Read latency: grant in cycle N, rvalid/rdata in N+1. Throughput is one access per cycle.
- F starvation bound: if f_req is held with no lock, F is granted within MAX_L_RUN+1 cycles.
- Simultaneous first requests: L granted, run_cnt becomes 1.
- A flush with no F in flight has no effect.
- Reset values (applied on the cycle rst is sampled high): run_cnt=0, lock_q=0, owner_q=NONE, kill_q=0. Consequently every registered output (f_rvalid, l_rvalid) is 0, and grants are purely combinational from requests.
- Reset mid-operation: a response in flight is dropped; no rvalid in the cycle after reset.

## Structure
- A shared package holds the owner enum (NONE=0, F=1, L=2) and the default for MAX_L_RUN. The fetch PC-hold logic uses the same package.
- One sub-module, imem_arb_pick, holds the combinational priority/starvation/lock decision: inputs are requests, run_cnt and lock_q; outputs are f_gnt and l_gnt. The top level holds the registers and muxes.

## Test plan
- F only, f_addr=0x0, 0x4, 0x8 on consecutive cycles -> f_gnt=1 each cycle; mem_addr follows; f_rvalid=1 with mem_rdata one cycle later; l_rvalid=0.
- L and F both requesting continuously, MAX_L_RUN=4 -> grant pattern L,L,L,L,F repeating; f_rvalid only in cycles after F grants.
- F granted at 0x10, f_flush in the next cycle -> f_rvalid stays 0. F granted at 0x20 in the flush cycle -> its response is delivered.
- L write, be=4'b0011, addr 0x100, wdata 0xDEADBEEF -> mem_we=1 and mem_be=3; no rvalid. L read of 0x100 -> l_rvalid with memory model data 0x0000BEEF.
- l_lock held for 3 cycles with f_req=1 and run_cnt saturated -> f_gnt=0 for all 3 cycles. f_gnt=1 in the first cycle after lock drops and l_req=0.
- rst asserted in the response cycle of an F read -> f_rvalid=0, run_cnt=0, owner_q=NONE on the next cycle.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared definitions for the instruction-memory arbiter and the fetch PC-hold logic.
// Holds the read-owner encoding, width/run defaults and the saturating run counter.
package imem_arb_pkg;

   localparam int XLEN_DEFAULT      = 32;
   localparam int MAX_L_RUN_DEFAULT = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_F    = 2'd1,
      OWN_L    = 2'd2
   } owner_e;

   function automatic logic [3:0] run_inc(input logic [3:0] cnt, input logic [3:0] max_run);
      return (cnt >= max_run) ? max_run : cnt + 4'd1;
   endfunction

endpackage

// File: rtl/imem_arb_if.sv
// Bundle of the fetch port, load/store port and memory-macro signals around imem_arb.
// slave is the arbiter's view; master is the view of everything surrounding it.
interface imem_arb_if #(parameter int XLEN = imem_arb_pkg::XLEN_DEFAULT);

   logic            f_req;
   logic [XLEN-1:0] f_addr;
   logic            f_flush;
   logic            f_gnt;
   logic            f_rvalid;
   logic [XLEN-1:0] f_rdata;

   logic            l_req;
   logic            l_we;
   logic [3:0]      l_be;
   logic [XLEN-1:0] l_addr;
   logic [XLEN-1:0] l_wdata;
   logic            l_lock;
   logic            l_gnt;
   logic            l_rvalid;
   logic [XLEN-1:0] l_rdata;

   logic            mem_en;
   logic            mem_we;
   logic [3:0]      mem_be;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [XLEN-1:0] mem_rdata;

   modport slave (
      input  f_req, f_addr, f_flush, l_req, l_we, l_be, l_addr, l_wdata, l_lock, mem_rdata,
      output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
             mem_en, mem_we, mem_be, mem_addr, mem_wdata
   );

   modport master (
      output f_req, f_addr, f_flush, l_req, l_we, l_be, l_addr, l_wdata, l_lock, mem_rdata,
      input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
             mem_en, mem_we, mem_be, mem_addr, mem_wdata
   );

endinterface

// File: rtl/imem_arb_pick.sv
// Combinational grant decision: L by default, F once L has run MAX_L_RUN times
// back to back, and nothing for F while L holds a lock.
module imem_arb_pick
   import imem_arb_pkg::*;
#(
   parameter int MAX_L_RUN = MAX_L_RUN_DEFAULT
) (
   input  logic       f_req,
   input  logic       l_req,
   input  logic [3:0] run_cnt,
   input  logic       lock_q,
   output logic       f_gnt,
   output logic       l_gnt
);

   localparam logic [3:0] RUN_MAX = 4'(MAX_L_RUN);

   logic f_due;

   always_comb begin
      f_due = f_req & (~l_req | (run_cnt == RUN_MAX));
      f_gnt = 1'b0;
      l_gnt = 1'b0;
      // A lock beats the starvation counter; F simply waits it out.
      if (lock_q) begin
         l_gnt = l_req;
      end else if (f_due) begin
         f_gnt = 1'b1;
      end else begin
         l_gnt = l_req;
      end
   end

endmodule

// File: rtl/imem_arb.sv
// Two-port arbiter for the single-port instruction memory: muxes the granted port
// onto the macro and steers the one-cycle-late read data back to its owner.
module imem_arb
   import imem_arb_pkg::*;
#(
   parameter int XLEN      = XLEN_DEFAULT,
   parameter int MAX_L_RUN = MAX_L_RUN_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   imem_arb_if.slave  bus
);

   localparam logic [3:0] RUN_MAX = 4'(MAX_L_RUN);

   logic            f_gnt;
   logic            l_gnt;
   logic            mem_we_int;
   logic [3:0]      be_mux;
   logic [XLEN-1:0] addr_mux;
   logic [XLEN-1:0] rdata_int;

   logic [3:0] run_cnt_reg, run_cnt_next;
   logic       lock_reg, lock_next;
   owner_e     owner_reg, owner_next;
   logic       kill_reg, kill_next;

   imem_arb_pick #(.MAX_L_RUN(MAX_L_RUN)) u_pick (
      .f_req   (bus.f_req),
      .l_req   (bus.l_req),
      .run_cnt (run_cnt_reg),
      .lock_q  (lock_reg),
      .f_gnt   (f_gnt),
      .l_gnt   (l_gnt)
   );

   assign mem_we_int = l_gnt & bus.l_we;
   assign addr_mux   = f_gnt ? bus.f_addr : bus.l_addr;

   // Reads always fetch the full word; only L writes use its byte enables.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_be
         assign be_mux[gi] = mem_we_int ? bus.l_be[gi] : 1'b1;
      end
   endgenerate

   assign bus.f_gnt     = f_gnt;
   assign bus.l_gnt     = l_gnt;
   assign bus.mem_en    = f_gnt | l_gnt;
   assign bus.mem_we    = mem_we_int;
   assign bus.mem_be    = be_mux;
   assign bus.mem_addr  = addr_mux;
   assign bus.mem_wdata = bus.l_wdata;

   always_comb begin
      run_cnt_next = run_cnt_reg;
      if (f_gnt || !bus.f_req) begin
         run_cnt_next = 4'd0;
      end else if (l_gnt) begin
         run_cnt_next = run_inc(run_cnt_reg, RUN_MAX);
      end

      lock_next = l_gnt & bus.l_lock;

      owner_next = OWN_NONE;
      if (f_gnt) begin
         owner_next = OWN_F;
      end else if (l_gnt && !bus.l_we) begin
         owner_next = OWN_L;
      end

      // A flush that coincides with a fresh F grant belongs to the new PC,
      // so it must not kill that grant's own response.
      kill_next = bus.f_flush & ~f_gnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_cnt_reg <= 4'd0;
         lock_reg    <= 1'b0;
         owner_reg   <= OWN_NONE;
         kill_reg    <= 1'b0;
      end else begin
         run_cnt_reg <= run_cnt_next;
         lock_reg    <= lock_next;
         owner_reg   <= owner_next;
         kill_reg    <= kill_next;
      end
   end

   assign rdata_int    = bus.mem_rdata;
   assign bus.f_rdata  = rdata_int;
   assign bus.l_rdata  = rdata_int;
   assign bus.f_rvalid = (owner_reg == OWN_F) & ~bus.f_flush & ~kill_reg;
   assign bus.l_rvalid = (owner_reg == OWN_L);

endmodule

// File: tb/tb_imem_arb.sv
// Directed bench for imem_arb: a per-cycle vector table plus hand-written
// sequences for the L/F rotation and reset in the middle of a read.
module tb_imem_arb;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imem_arb_if #(.XLEN(32)) bus ();

   imem_arb #(.XLEN(32), .MAX_L_RUN(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Memory model: 256 words, one-cycle read latency. Words below 0x100 hold
   // 0xC0DE0000|addr, the rest hold zero; reloaded whenever rst is high.
   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (rst) begin
         for (int w = 0; w < 256; w++)
            mem[w] <= (w < 64) ? (32'hC0DE0000 | 32'(w * 4)) : 32'h0;
      end else if (bus.mem_en) begin
         if (bus.mem_we) begin
            for (int b = 0; b < 4; b++)
               if (bus.mem_be[b])
                  mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
         end else begin
            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
         end
      end
   end

   typedef struct {
      logic        rst;
      logic        f_req;
      logic [31:0] f_addr;
      logic        f_flush;
      logic        l_req;
      logic        l_we;
      logic [3:0]  l_be;
      logic [31:0] l_addr;
      logic [31:0] l_wdata;
      logic        l_lock;
      logic [1:0]  e_gnt;   // {f_gnt, l_gnt}
      logic [1:0]  e_rv;    // {f_rvalid, l_rvalid}
      logic [31:0] e_rdata;
      logic        e_we;
      logic [3:0]  e_be;
      logic [31:0] e_addr;
   } vec_t;

   localparam int NV = 30;
   vec_t vecs [NV];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   function automatic vec_t mk(
      input logic r, input logic fr, input logic [31:0] fa, input logic ff,
      input logic lr, input logic lw, input logic [3:0] lbe, input logic [31:0] la,
      input logic [31:0] lwd, input logic ll,
      input logic [1:0] eg, input logic [1:0] erv, input logic [31:0] erd,
      input logic ewe, input logic [3:0] ebe, input logic [31:0] ea);
      vec_t v;
      v.rst = r;   v.f_req = fr; v.f_addr = fa; v.f_flush = ff;
      v.l_req = lr; v.l_we = lw; v.l_be = lbe; v.l_addr = la; v.l_wdata = lwd; v.l_lock = ll;
      v.e_gnt = eg; v.e_rv = erv; v.e_rdata = erd; v.e_we = ewe; v.e_be = ebe; v.e_addr = ea;
      return v;
   endfunction

   task automatic set_in(input logic r, input logic fr, input logic [31:0] fa, input logic ff,
                         input logic lr, input logic lw, input logic [3:0] lbe,
                         input logic [31:0] la, input logic [31:0] lwd, input logic ll);
      rst         = r;
      bus.f_req   = fr;
      bus.f_addr  = fa;
      bus.f_flush = ff;
      bus.l_req   = lr;
      bus.l_we    = lw;
      bus.l_be    = lbe;
      bus.l_addr  = la;
      bus.l_wdata = lwd;
      bus.l_lock  = ll;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic show();
      $display("cyc %0d rst=%b f_gnt=%b l_gnt=%b f_rv=%b l_rv=%b mem_en=%b we=%b be=%h addr=%h rdata=%h",
               cyc, rst, bus.f_gnt, bus.l_gnt, bus.f_rvalid, bus.l_rvalid,
               bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_rdata);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Checks grants and rvalids (with rdata when valid) in the current cycle.
   task automatic chk_gr(input string tag, input logic [1:0] eg, input logic [1:0] erv,
                         input logic [31:0] erd);
      @(negedge clk);
      show();
      chk({tag, " f_gnt"},    32'(bus.f_gnt),    32'(eg[1]));
      chk({tag, " l_gnt"},    32'(bus.l_gnt),    32'(eg[0]));
      chk({tag, " mem_en"},   32'(bus.mem_en),   32'(eg[1] | eg[0]));
      chk({tag, " f_rvalid"}, 32'(bus.f_rvalid), 32'(erv[1]));
      chk({tag, " l_rvalid"}, 32'(bus.l_rvalid), 32'(erv[0]));
      if (erv[1]) chk({tag, " f_rdata"}, bus.f_rdata, erd);
      if (erv[0]) chk({tag, " l_rdata"}, bus.l_rdata, erd);
   endtask

   initial begin
      //          rst fr f_addr      ff lr lw be     l_addr      l_wdata       ll  gnt    rv     rdata          we be     addr
      vecs[0]  = mk(1, 0, 32'h0,     0, 0, 0, 4'h0, 32'h0,     32'h0,        0, 2'b00, 2'b00, 32'h0,         0, 4'hF, 32'h0);
      vecs[1]  = mk(0, 0, 32'h0,     0, 0, 0, 4'h0, 32'h0,     32'h0,        0, 2'b00, 2'b00, 32'h0,         0, 4'hF, 32'h0);
      vecs[2]  = mk(0, 1, 32'h0,     0, 0, 0, 4'h0, 32'h0,     32'h0,        0, 2'b10, 2'b00, 32'h0,         0, 4'hF, 32'h0);
      vecs[3]  = mk(0, 1, 32'h4,     0, 0, 0, 4'h0, 32'h0,     32'h0,        0, 2'b10, 2'b10, 32'hC0DE0000,  0, 4'hF, 32'h4);
      vecs[4]  = mk(0, 1, 32'h8,     0, 0, 0, 4'h0, 32'h0,     32'h0,        0, 2'b10, 2'b10, 32'hC0DE0004,  0, 4'hF, 32'h8);
      vecs[5]  = mk(0, 0, 32'h0,     0, 0, 0, 4'h0, 32'h0,     32'h0,        0, 2'b00, 2'b10, 32'hC0DE0008,  0, 4'hF, 32'h0);
      vecs[6]  = mk(0, 1, 32'h10,    0, 0, 0, 4'h0, 32'h0,     32'h0,        0, 2'b10, 2'b00, 32'h0,         0, 4'hF, 32'h10);
      vecs[7]  = mk(0, 1, 32'h20,    1, 0, 0, 4'h0, 32'h0,     32'h0,        0, 2'b10, 2'b00, 32'h0,         0, 4'hF, 32'h20);
      vecs[8]  = mk(0, 0, 32'h0,     0, 0, 0, 4'h0, 32'h0,     32'h0,        0, 2'b00, 2'b10, 32'hC0DE0020,  0, 4'hF, 32'h0);
      vecs[9]  = mk(0, 0, 32'h0,     1, 0, 0, 4'h0, 32'h0,     32'h0,        0, 2'b00, 2'b00, 32'h0,         0, 4'hF, 32'h0);
      vecs[10] = mk(0, 1, 32'h30,    0, 0, 0, 4'h0, 32'h0,     32'h0,        0, 2'b10, 2'b00, 32'h0,         0, 4'hF, 32'h30);
      vecs[11] = mk(0, 0, 32'h0,     0, 0, 0, 4'h0, 32'h0,     32'h0,        0, 2'b00, 2'b10, 32'hC0DE0030,  0, 4'hF, 32'h0);
      vecs[12] = mk(0, 0, 32'h0,     0, 1, 1, 4'h3, 32'h100,   32'hDEADBEEF, 0, 2'b01, 2'b00, 32'h0,         1, 4'h3, 32'h100);
      vecs[13] = mk(0, 0, 32'h0,     0, 1, 0, 4'h0, 32'h100,   32'h0,        0, 2'b01, 2'b00, 32'h0,         0, 4'hF, 32'h100);
      vecs[14] = mk(0, 0, 32'h0,     0, 0, 0, 4'h0, 32'h0,     32'h0,        0, 2'b00, 2'b01, 32'h0000BEEF,  0, 4'hF, 32'h0);
      vecs[15] = mk(0, 1, 32'h40,    0, 1, 0, 4'h0, 32'h8,     32'h0,        0, 2'b01, 2'b00, 32'h0,         0, 4'hF, 32'h8);
      vecs[16] = mk(0, 1, 32'h40,    0, 0, 0, 4'h0, 32'h0,     32'h0,        0, 2'b10, 2'b01, 32'hC0DE0008,  0, 4'hF, 32'h40);
      vecs[17] = mk(0, 0, 32'h0,     0, 0, 0, 4'h0, 32'h0,     32'h0,        0, 2'b00, 2'b10, 32'hC0DE0040,  0, 4'hF, 32'h0);
      vecs[18] = mk(0, 1, 32'h50,    0, 1, 0, 4'h0, 32'hC,     32'h0,        0, 2'b01, 2'b00, 32'h0,         0, 4'hF, 32'hC);
      vecs[19] = mk(0, 1, 32'h50,    0, 1, 0, 4'h0, 32'hC,     32'h0,        0, 2'b01, 2'b01, 32'hC0DE000C,  0, 4'hF, 32'hC);
      vecs[20] = mk(0, 1, 32'h50,    0, 1, 0, 4'h0, 32'hC,     32'h0,        0, 2'b01, 2'b01, 32'hC0DE000C,  0, 4'hF, 32'hC);
      vecs[21] = mk(0, 1, 32'h50,    0, 1, 0, 4'h0, 32'hC,     32'h0,        1, 2'b01, 2'b01, 32'hC0DE000C,  0, 4'hF, 32'hC);
      vecs[22] = mk(0, 1, 32'h50,    0, 1, 0, 4'h0, 32'hC,     32'h0,        1, 2'b01, 2'b01, 32'hC0DE000C,  0, 4'hF, 32'hC);
      vecs[23] = mk(0, 1, 32'h50,    0, 1, 0, 4'h0, 32'hC,     32'h0,        1, 2'b01, 2'b01, 32'hC0DE000C,  0, 4'hF, 32'hC);
      vecs[24] = mk(0, 1, 32'h50,    0, 1, 0, 4'h0, 32'hC,     32'h0,        0, 2'b01, 2'b01, 32'hC0DE000C,  0, 4'hF, 32'hC);
      vecs[25] = mk(0, 1, 32'h50,    0, 0, 0, 4'h0, 32'h0,     32'h0,        0, 2'b10, 2'b01, 32'hC0DE000C,  0, 4'hF, 32'h50);
      vecs[26] = mk(0, 0, 32'h0,     0, 1, 0, 4'h0, 32'h14,    32'h0,        1, 2'b01, 2'b10, 32'hC0DE0050,  0, 4'hF, 32'h14);
      vecs[27] = mk(0, 1, 32'h54,    0, 0, 0, 4'h0, 32'h0,     32'h0,        0, 2'b00, 2'b01, 32'hC0DE0014,  0, 4'hF, 32'h0);
      vecs[28] = mk(0, 1, 32'h54,    0, 0, 0, 4'h0, 32'h0,     32'h0,        0, 2'b10, 2'b00, 32'h0,         0, 4'hF, 32'h54);
      vecs[29] = mk(0, 0, 32'h0,     0, 0, 0, 4'h0, 32'h0,     32'h0,        0, 2'b00, 2'b10, 32'hC0DE0054,  0, 4'hF, 32'h0);

      bus.mem_rdata = 32'h0;
      set_in(1, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
      next_cycle();

      for (int i = 0; i < NV; i++) begin
         set_in(vecs[i].rst, vecs[i].f_req, vecs[i].f_addr, vecs[i].f_flush, vecs[i].l_req,
                vecs[i].l_we, vecs[i].l_be, vecs[i].l_addr, vecs[i].l_wdata, vecs[i].l_lock);
         chk_gr($sformatf("v%0d", i), vecs[i].e_gnt, vecs[i].e_rv, vecs[i].e_rdata);
         if (vecs[i].e_gnt != 2'b00) begin
            chk($sformatf("v%0d mem_addr", i), bus.mem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d mem_we", i), 32'(bus.mem_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d mem_be", i), 32'(bus.mem_be), 32'(vecs[i].e_be));
            if (vecs[i].e_we)
               chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, vecs[i].l_wdata);
         end
         next_cycle();
      end

      // Both ports requesting nonstop: L,L,L,L,F repeating from run_cnt=0.
      set_in(0, 1, 32'h60, 0, 1, 0, 4'h0, 32'h100, 32'h0, 0);
      for (int k = 0; k < 15; k++) begin
         logic f_now;
         logic f_prev;
         f_now  = (k % 5) == 4;
         f_prev = (k % 5) == 0 && k > 0;
         if (k == 0)
            chk_gr($sformatf("rot%0d", k), f_now ? 2'b10 : 2'b01, 2'b00, 32'h0);
         else
            chk_gr($sformatf("rot%0d", k), f_now ? 2'b10 : 2'b01,
                   f_prev ? 2'b10 : 2'b01, f_prev ? 32'hC0DE0060 : 32'h0000BEEF);
         next_cycle();
      end

      // F read granted, then rst in its response cycle: the response shows this
      // cycle, nothing follows, and the L rotation restarts from run_cnt=0.
      set_in(0, 1, 32'h24, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
      chk_gr("rs0", 2'b10, 2'b10, 32'hC0DE0060);
      next_cycle();
      set_in(1, 1, 32'h24, 0, 1, 0, 4'h0, 32'h8, 32'h0, 1);
      chk_gr("rs1", 2'b01, 2'b10, 32'hC0DE0024);
      next_cycle();
      set_in(0, 1, 32'h24, 0, 1, 0, 4'h0, 32'h8, 32'h0, 0);
      chk_gr("rs2", 2'b01, 2'b00, 32'h0);
      next_cycle();
      for (int k = 3; k < 6; k++) begin
         chk_gr($sformatf("rs%0d", k), 2'b01, 2'b01, 32'hC0DE0008);
         next_cycle();
      end
      chk_gr("rs6", 2'b10, 2'b01, 32'hC0DE0008);
      next_cycle();
      set_in(0, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
      chk_gr("rs7", 2'b00, 2'b10, 32'hC0DE0024);
      next_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
